// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader: boot loader that turns a framed byte stream into instruction |
// | memory writes and holds the core in reset until the frame checks out.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_LO = 3'd1,
    S_CNT_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_RUN    = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                rx_ready_q, rx_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_waddr_q, imem_waddr_d;
  logic [31:0]         imem_wdata_q, imem_wdata_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [7:0]          xor_q, xor_d;
  logic [ADDR_W:0]     widx_q, widx_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         word_q, word_d;

  logic                w_acc;
  logic                w_sync;
  logic [15:0]         w_count;
  logic                w_count_ovf;
  logic [ADDR_W:0]     w_widx_inc;
  logic                w_last_word;

  assign w_acc       = rx_valid && rx_ready_q;
  assign w_sync      = (rx_data == SYNC_BYTE);
  assign w_count     = {rx_data, cnt_q[7:0]};
  // Word index carries one extra bit so that a full 2^ADDR_W load is legal.
  assign w_count_ovf = ({1'b0, w_count} > (17'd1 << ADDR_W));
  assign w_widx_inc  = widx_q + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last_word = (17'(w_widx_inc) == {1'b0, cnt_q});

  always_comb begin
    state_d      = state_q;
    rx_ready_d   = 1'b1;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    core_rst_n_d = core_rst_n_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    cnt_d        = cnt_q;
    xor_d        = xor_q;
    widx_d       = widx_q;
    lane_d       = lane_q;
    word_d       = word_q;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (w_acc && w_sync) begin
          state_d = S_CNT_LO;
          busy_d  = 1'b1;
          error_d = 1'b0;
          xor_d   = 8'h00;
          widx_d  = '0;
          lane_d  = 2'd0;
        end
      end

      S_CNT_LO: begin
        if (w_acc) begin
          cnt_d[7:0] = rx_data;
          xor_d      = xor_q ^ rx_data;
          state_d    = S_CNT_HI;
        end
      end

      S_CNT_HI: begin
        if (w_acc) begin
          cnt_d[15:8] = rx_data;
          xor_d       = xor_q ^ rx_data;
          if (w_count_ovf) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else if (w_count == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (w_acc) begin
          xor_d  = xor_q ^ rx_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              imem_we_d    = 1'b1;
              imem_wdata_d = {rx_data, word_q};
              imem_waddr_d = widx_q[ADDR_W-1:0];
              widx_d       = w_widx_inc;
              if (w_last_word) begin
                state_d = S_CHECK;
              end
            end
          endcase
        end
      end

      S_CHECK: begin
        if (w_acc) begin
          busy_d = 1'b0;
          if (rx_data == xor_q) begin
            state_d      = S_RUN;
            done_d       = 1'b1;
            core_rst_n_d = 1'b1;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end

      S_RUN: begin
        // Terminal: bytes are still accepted so the sender never stalls.
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= 32'h0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cnt_q        <= 16'h0;
      xor_q        <= 8'h00;
      widx_q       <= '0;
      lane_q       <= 2'd0;
      word_q       <= 24'h0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cnt_q        <= cnt_d;
      xor_q        <= xor_d;
      widx_q       <= widx_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_loader: directed frames checked against a byte-position model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int ADDR_W = 4;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              busy;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: tracks the byte position inside the current frame and derives
  // count, lane, word number and checksum arithmetically from it.
  logic              exp_ready = 1'b0;
  logic              exp_we = 1'b0;
  logic [ADDR_W-1:0] exp_waddr = '0;
  logic [31:0]       exp_wdata = 32'h0;
  logic              exp_core = 1'b0;
  logic              exp_busy = 1'b0;
  logic              exp_done = 1'b0;
  logic              exp_err = 1'b0;
  bit                m_in_frame = 1'b0;
  bit                m_acc;
  int                m_pos = 0;
  int                m_p;
  int                m_n = 0;
  logic [7:0]        m_cks = 8'h00;
  logic [31:0]       m_word = 32'h0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_ready = 0; exp_we = 0; exp_waddr = '0; exp_wdata = 0;
      exp_core = 0; exp_busy = 0; exp_done = 0; exp_err = 0;
      m_in_frame = 0; m_pos = 0; m_n = 0; m_cks = 0; m_word = 0;
    end else begin
      m_acc     = rx_valid && exp_ready;
      exp_ready = 1'b1;
      exp_we    = 1'b0;
      if (m_acc && !exp_done) begin
        if (!m_in_frame) begin
          if (rx_data == 8'hA5) begin
            m_in_frame = 1; m_pos = 0; m_n = 0; m_cks = 0;
            exp_busy = 1; exp_err = 0;
          end
        end else begin
          m_p = m_pos;
          m_pos++;
          if (m_p < 2) begin
            m_cks ^= rx_data;
            m_n |= int'(rx_data) << (8 * m_p);
            if (m_p == 1 && m_n > (1 << ADDR_W)) begin
              exp_err = 1; exp_busy = 0; m_in_frame = 0;
            end
          end else if (m_p < 2 + 4 * m_n) begin
            m_cks ^= rx_data;
            m_word[8 * ((m_p - 2) % 4) +: 8] = rx_data;
            if ((m_p - 2) % 4 == 3) begin
              exp_we    = 1;
              exp_waddr = ADDR_W'((m_p - 2) / 4);
              exp_wdata = m_word;
            end
          end else begin
            m_in_frame = 0;
            exp_busy   = 0;
            if (rx_data == m_cks) begin
              exp_done = 1; exp_core = 1;
            end else begin
              exp_err = 1;
            end
          end
        end
      end
    end
  end

  // Compare process plus a behavioural memory fed by the DUT write port.
  logic [31:0] mem_dut [0:(1<<ADDR_W)-1];
  int          wr_cnt = 0;

  initial forever begin
    @(negedge clk);
    chk("rx_ready",   32'(rx_ready),   32'(exp_ready));
    chk("imem_we",    32'(imem_we),    32'(exp_we));
    chk("imem_waddr", 32'(imem_waddr), 32'(exp_waddr));
    chk("imem_wdata", imem_wdata,      exp_wdata);
    chk("core_rst_n", 32'(core_rst_n), 32'(exp_core));
    chk("busy",       32'(busy),       32'(exp_busy));
    chk("done",       32'(done),       32'(exp_done));
    chk("error",      32'(error),      32'(exp_err));
    if (imem_we === 1'b1) begin
      mem_dut[imem_waddr] = imem_wdata;
      wr_cnt++;
    end
  end

  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bq_t f, input bit rnd_gaps);
    foreach (f[i]) send(f[i], rnd_gaps ? int'($urandom_range(5, 0)) : 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    wr_cnt = 0;
    foreach (mem_dut[i]) mem_dut[i] = 32'hDEAD_BEEF;
  endtask

  bq_t good = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
  bq_t bad  = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                8'h13, 8'h01, 8'hA0, 8'h00, 8'h74};
  bq_t big;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset rx_ready", 32'(rx_ready), 0);
    chk("reset core_rst_n", 32'(core_rst_n), 0);
    chk("reset wdata", imem_wdata, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rx_ready after reset", 32'(rx_ready), 1);
    foreach (mem_dut[i]) mem_dut[i] = 32'hDEAD_BEEF;

    // Two-word load, then a sync byte in RUN must be ignored.
    send_frame(good, 0);
    chk("load done", 32'(done), 1);
    chk("load core_rst_n", 32'(core_rst_n), 1);
    chk("load error", 32'(error), 0);
    chk("load word0", mem_dut[0], 32'h0050_0093);
    chk("load word1", mem_dut[1], 32'h00A0_0113);
    chk("load writes", wr_cnt, 2);
    send(8'hA5, 0); send(8'h01, 0);
    chk("run ignores sync busy", 32'(busy), 0);

    // Bad checksum, then a correct retry.
    do_reset();
    send_frame(bad, 0);
    chk("badcks error", 32'(error), 1);
    chk("badcks core_rst_n", 32'(core_rst_n), 0);
    chk("badcks writes", wr_cnt, 2);
    send(8'hA5, 0);
    chk("retry sync clears error", 32'(error), 0);
    chk("retry sync busy", 32'(busy), 1);
    good.pop_front();
    send_frame(good, 0);
    good.push_front(8'hA5);
    chk("retry done", 32'(done), 1);
    chk("retry core_rst_n", 32'(core_rst_n), 1);

    // Count overflow (17 words > 16), trailing junk, then an empty frame.
    do_reset();
    send(8'hA5, 0); send(8'h11, 0); send(8'h00, 0);
    chk("ovf error", 32'(error), 1);
    chk("ovf busy", 32'(busy), 0);
    send(8'h93, 1); send(8'h00, 0); send(8'h50, 2);
    chk("ovf no writes", wr_cnt, 0);
    send_frame('{8'hA5, 8'h00, 8'h00, 8'h00}, 0);
    chk("empty done", 32'(done), 1);
    chk("empty core_rst_n", 32'(core_rst_n), 1);
    chk("empty no writes", wr_cnt, 0);

    // Leading garbage and random idle gaps.
    do_reset();
    send_frame('{8'h00, 8'hFF, 8'h5A}, 1);
    send_frame(good, 1);
    chk("gaps word0", mem_dut[0], 32'h0050_0093);
    chk("gaps word1", mem_dut[1], 32'h00A0_0113);
    chk("gaps done", 32'(done), 1);

    // Full-capacity load: 16 words, payload bytes 0..63, checksum 0x10.
    do_reset();
    big = '{8'hA5, 8'h10, 8'h00};
    for (int i = 0; i < 64; i++) big.push_back(8'(i));
    big.push_back(8'h10);
    send_frame(big, 0);
    chk("full word0", mem_dut[0], 32'h0302_0100);
    chk("full word15", mem_dut[15], 32'h3F3E_3D3C);
    chk("full writes", wr_cnt, 16);
    chk("full done", 32'(done), 1);

    // Asynchronous reset in the middle of the first word.
    do_reset();
    for (int i = 0; i < 6; i++) send(good[i], 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rx_ready", 32'(rx_ready), 0);
    chk("async busy", 32'(busy), 0);
    chk("async core_rst_n", 32'(core_rst_n), 0);
    chk("async we", 32'(imem_we), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    wr_cnt = 0;
    send_frame(good, 0);
    chk("post-reset word0", mem_dut[0], 32'h0050_0093);
    chk("post-reset word1", mem_dut[1], 32'h00A0_0113);
    chk("post-reset writes", wr_cnt, 2);
    chk("post-reset done", 32'(done), 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
